// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction and data requesters, one transaction in flight.
// Fixed priority (data wins ties) by default; define ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [2:0]  d_size,
  input  logic [3:0]  d_strobe,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic        m_write,
  output logic [2:0]  m_size,
  output logic [3:0]  m_strobe,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       owner;
  logic       winner;
  logic       any_req;
  logic       in_req;
  logic       in_wait;

  assign any_req = i_valid | d_valid;

`ifdef ARB_RR_EN
  logic last_grant;

  // On a tie, grant whoever was not served last; a lone requester always wins.
  always_comb begin
    winner = d_valid;
    if (i_valid && d_valid) winner = ~last_grant;
  end

  always_ff @(posedge clk) begin
    if (!resetn)                       last_grant <= 1'b0;
    else if (state == IDLE && any_req) last_grant <= winner;
  end
`else
  always_comb winner = d_valid;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)   state_nxt = REQ;
      REQ:     if (m_addr_ok) state_nxt = WAIT;
      WAIT:    if (m_data_ok) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) owner <= winner;
    end
  end

  // Gating with resetn keeps every handshake low for the whole reset cycle.
  assign in_req  = resetn && (state == REQ);
  assign in_wait = resetn && (state == WAIT);

  assign m_valid  = in_req;
  assign m_addr   = !in_req ? 32'd0 : (owner ? d_addr : i_addr);
  assign m_write  = in_req && owner && d_write;
  assign m_size   = !in_req ? 3'd0 : (owner ? d_size : 3'b010);
  assign m_strobe = (in_req && owner) ? d_strobe : 4'd0;
  assign m_wdata  = (in_req && owner) ? d_wdata : 32'd0;

  assign i_addr_ok = in_req  && !owner && m_addr_ok;
  assign d_addr_ok = in_req  &&  owner && m_addr_ok;
  assign i_data_ok = in_wait && !owner && m_data_ok;
  assign d_data_ok = in_wait &&  owner && m_data_ok;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on posedge; resetn  in  1  reset, synchronous, active-low.
REQ-002 SHALL have instruction requester ports: i_valid  in  1  fetch request; i_addr  in  32  fetch address; i_addr_ok  out  1  request accepted; i_data_ok  out  1  read data valid; i_rdata  out  32  read data.
REQ-003 SHALL have data requester ports: d_valid  in  1  load/store request; d_addr  in  32; d_write  in  1  1=store; d_size  in  3  access size; d_strobe  in  4  byte enables; d_wdata  in  32; d_addr_ok  out  1; d_data_ok  out  1; d_rdata  out  32.
REQ-004 SHALL have downstream port: m_valid  out  1; m_addr  out  32; m_write  out  1; m_size  out  3; m_strobe  out  4; m_wdata  out  32; m_addr_ok  in  1; m_data_ok  in  1; m_rdata  in  32.

Function
REQ-005 SHALL share one downstream port between both requesters, with at most one transaction outstanding.
REQ-006 SHALL implement FSM states IDLE, REQ, WAIT and a registered owner bit (0=instr, 1=data).
REQ-007 SHALL, in IDLE with any valid request, register the winner into owner and go to REQ next cycle; with no valid request, stay in IDLE.
REQ-008 SHALL drive m_valid=1 only in REQ, with m_* fields muxed combinationally from the owner's inputs.
REQ-009 SHALL tie m_write=0, m_strobe=0, m_size=3'b010 and m_wdata=0 for instruction ownership.
REQ-010 SHALL pass m_addr_ok to the owner's addr_ok in the same cycle while in REQ; m_addr_ok in REQ moves the FSM to WAIT.
REQ-011 SHALL pass m_data_ok and m_rdata to the owner's data_ok/rdata in the same cycle while in WAIT; m_data_ok in WAIT moves the FSM to IDLE.
REQ-012 SHALL hold the other requester's addr_ok and data_ok at 0 at all times; rdata outputs SHALL be m_rdata (don't-care when data_ok=0).
REQ-013 SHALL add exactly one arbitration cycle: minimum transaction = IDLE(1) + REQ(1) + WAIT(1) = 3 cycles when slave answers in the same cycle.
REQ-014 SHALL NOT drop or re-select a requester that lowers valid while in REQ; requesters hold valid and fields stable until addr_ok (protocol rule, not checked).
REQ-015 SHALL ignore m_data_ok in IDLE/REQ and m_addr_ok in IDLE/WAIT; no forwarding to either requester.
REQ-016 SHALL make simultaneous i_valid and d_valid in IDLE resolve per REQ-021/REQ-022.

Reset
REQ-017 SHALL on resetn=0 at posedge go to IDLE, owner=0, last-grant register=0, regardless of state.
REQ-018 SHALL hold all outputs 0 during and after reset until a new grant (m_valid=0, all addr_ok/data_ok=0).
REQ-019 SHALL, for reset during WAIT, drop the in-flight response: a later m_data_ok in IDLE is ignored per REQ-015.

Configuration
REQ-020 SHALL use the macro ARB_RR_EN to select the arbitration policy.
REQ-021 SHALL, without ARB_RR_EN, use fixed priority: data wins a tie.
REQ-022 SHALL, with ARB_RR_EN, use round-robin: the 1-bit last-grant register updates on every grant, and a tie goes to the requester not last granted; a single requester is always granted.

Verification
REQ-023 SHALL cover a single fetch: i_valid=1, i_addr=0xBFC00000, slave addr_ok in REQ, data_ok one cycle later with 0x3C080001 -> m_addr=0xBFC00000, m_write=0, i_addr_ok pulses once, i_data_ok with i_rdata=0x3C080001, d_* outputs stay 0.
REQ-024 SHALL cover a store: d_valid=1, d_write=1, d_addr=0x80000010, d_strobe=4'b0011, d_wdata=0x1234ABCD -> identical m_* values, d_addr_ok then d_data_ok, FSM back in IDLE.
REQ-025 SHALL cover a tie without ARB_RR_EN: both valid for 3 back-to-back transactions -> all three grants go to data; instruction is granted after d_valid drops.
REQ-026 SHALL cover a tie with ARB_RR_EN: both valid continuously, last-grant=0 after reset -> grants alternate D, I, D, I.
REQ-027 SHALL cover slave stall: m_addr_ok held 0 for 5 cycles in REQ -> m_valid and fields stable for 5 cycles, no addr_ok to either requester.
REQ-028 SHALL cover reset mid-WAIT: resetn=0 one cycle, then m_data_ok=1 -> no data_ok to either requester, m_valid=0, FSM in IDLE.
